// File: rtl/frame_out_pkg.sv
// Shared types for the frame output stage: flush FSM encoding and the RGB565
// packing used when pixels are streamed out to SD-RAM.
package frame_out_pkg;

    typedef enum logic [1:0] {
        FO_IDLE  = 2'd0,
        FO_FL_RD = 2'd1,
        FO_FL_WR = 2'd2,
        FO_DONE  = 2'd3
    } fo_state_t;

    // Bit positions inside a 24-bit R,G,B pixel (R in the MSBs).
    localparam int R_HI = 23;
    localparam int R_LO = 19;
    localparam int G_HI = 15;
    localparam int G_LO = 10;
    localparam int B_HI = 7;
    localparam int B_LO = 3;

    function automatic logic [15:0] pack_pixel(input logic [23:0] px);
        return {px[R_HI:R_LO], px[G_HI:G_LO], px[B_HI:B_LO]};
    endfunction

endpackage

// File: rtl/frame_output_controller_if.sv
// Blender and SD-RAM signals of the frame output stage. master = blender/SD side
// driving requests, slave = the output controller.
interface frame_output_controller_if #(
    parameter int IDX_W     = 8,
    parameter int PX_W      = 24,
    parameter int SD_DATA_W = 16,
    parameter int SD_ADDR_W = 32
);
    logic [IDX_W-1:0]     px_index;
    logic                 wr_en;
    logic [PX_W-1:0]      wr_data;
    logic                 rd_en;
    logic [PX_W-1:0]      rd_data;
    logic                 rd_valid;
    logic                 frame_ready;
    logic                 busy;
    logic                 sd_write;
    logic [SD_DATA_W-1:0] sd_wdata;
    logic [SD_ADDR_W-1:0] sd_address;
    logic                 sd_wait;
    logic                 frame_done;

    modport master (
        output px_index, wr_en, wr_data, rd_en, frame_ready, sd_wait,
        input  rd_data, rd_valid, busy, sd_write, sd_wdata, sd_address, frame_done
    );

    modport slave (
        input  px_index, wr_en, wr_data, rd_en, frame_ready, sd_wait,
        output rd_data, rd_valid, busy, sd_write, sd_wdata, sd_address, frame_done
    );
endinterface

// File: rtl/fo_pixel_buffer.sv
// Purpose: one-tile pixel store, 1R1W synchronous RAM, array not reset.
// Latency: read data registered, valid the cycle after rd_en; read-before-write on same index.
// Backpressure: none, both ports accept every cycle.
module fo_pixel_buffer #(
    parameter int NUM_PIXELS = 256,
    parameter int PX_W       = 24,
    parameter int IDX_W      = $clog2(NUM_PIXELS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [PX_W-1:0]  wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [PX_W-1:0]  rd_data
);

    logic [PX_W-1:0] mem [NUM_PIXELS];
    logic [PX_W-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_output_controller.sv
// Purpose: tile pixel buffer serving blender RMW, flushed to SD-RAM on frame_ready (option FRAME_OUT_CLEAR_EN: zero each pixel as it is sent).
// Latency: blender read 1 cycle; flush 2 cycles/pixel + 1 DONE cycle when sd_wait stays low.
// Backpressure: sd_wait stalls the current SD word; blender traffic dropped while busy.
module frame_output_controller
    import frame_out_pkg::*;
#(
    parameter int                   NUM_PIXELS = 256,
    parameter int                   NUM_CH     = 3,
    parameter int                   CH_W       = 8,
    parameter int                   SD_DATA_W  = 16,
    parameter int                   SD_ADDR_W  = 32,
    parameter logic [SD_ADDR_W-1:0] BASE_ADDR  = '0,
    parameter bit                   PACK_565   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    frame_output_controller_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_PIXELS);
    localparam int PX_W  = NUM_CH * CH_W;
    localparam int BYTES = SD_DATA_W / 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

    fo_state_t            state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 pending_q, pending_d;
    logic                 busy_q, busy_d;
    logic                 sd_write_q, sd_write_d;
    logic [SD_ADDR_W-1:0] sd_address_q, sd_address_d;
    logic                 frame_done_q, frame_done_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [PX_W-1:0]      rd_hold_q, rd_hold_d;

    logic                 accept;
    logic                 clear_wr;
    logic                 blk_wr;
    logic                 blk_rd;
    logic                 buf_wr_en;
    logic [IDX_W-1:0]     buf_wr_idx;
    logic [PX_W-1:0]      buf_wr_data;
    logic                 buf_rd_en;
    logic [IDX_W-1:0]     buf_rd_idx;
    logic [PX_W-1:0]      buf_rd_data;
    logic [SD_DATA_W-1:0] sd_word;

    assign accept = sd_write_q & ~bus.sd_wait;
    assign blk_wr = bus.wr_en & (state_q == FO_IDLE);
    assign blk_rd = bus.rd_en & (state_q == FO_IDLE);

`ifdef FRAME_OUT_CLEAR_EN
    assign clear_wr = (state_q == FO_FL_WR) & accept;
`else
    assign clear_wr = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pending_d    = pending_q;
        sd_address_d = sd_address_q;
        case (state_q)
            FO_IDLE: begin
                if (bus.frame_ready) begin
                    state_d = FO_FL_RD;
                    idx_d   = '0;
                end
            end
            FO_FL_RD: begin
                state_d      = FO_FL_WR;
                sd_address_d = SD_ADDR_W'(BASE_ADDR + SD_ADDR_W'(idx_q) * SD_ADDR_W'(BYTES));
            end
            FO_FL_WR: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = FO_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = FO_FL_RD;
                    end
                end
            end
            FO_DONE: begin
                // A request arriving during DONE itself is treated like a pending one.
                if (pending_q || bus.frame_ready) begin
                    pending_d = 1'b0;
                    idx_d     = '0;
                    state_d   = FO_FL_RD;
                end else begin
                    state_d = FO_IDLE;
                end
            end
            default: state_d = FO_IDLE;
        endcase
        if (bus.frame_ready && (state_q == FO_FL_RD || state_q == FO_FL_WR)) begin
            pending_d = 1'b1;
        end

        busy_d       = (state_d != FO_IDLE);
        sd_write_d   = (state_d == FO_FL_WR);
        frame_done_d = (state_d == FO_DONE);
        rd_valid_d   = blk_rd;
        rd_hold_d    = rd_valid_q ? buf_rd_data : rd_hold_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FO_IDLE;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            busy_q       <= 1'b0;
            sd_write_q   <= 1'b0;
            sd_address_q <= '0;
            frame_done_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_hold_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            busy_q       <= busy_d;
            sd_write_q   <= sd_write_d;
            sd_address_q <= sd_address_d;
            frame_done_q <= frame_done_d;
            rd_valid_q   <= rd_valid_d;
            rd_hold_q    <= rd_hold_d;
        end
    end

    // One shared read port: flush reads own it outside IDLE, blender reads inside.
    always_comb begin
        buf_rd_en   = blk_rd | (state_q == FO_FL_RD);
        buf_rd_idx  = (state_q == FO_FL_RD) ? idx_q : bus.px_index;
        buf_wr_en   = blk_wr | clear_wr;
        buf_wr_idx  = blk_wr ? bus.px_index : idx_q;
        buf_wr_data = blk_wr ? bus.wr_data : '0;
    end

    fo_pixel_buffer #(
        .NUM_PIXELS (NUM_PIXELS),
        .PX_W       (PX_W),
        .IDX_W      (IDX_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (buf_wr_en),
        .wr_idx  (buf_wr_idx),
        .wr_data (buf_wr_data),
        .rd_en   (buf_rd_en),
        .rd_idx  (buf_rd_idx),
        .rd_data (buf_rd_data)
    );

    // The RAM output register only reloads in FL_RD, so the word is stable across sd_wait.
    if (PACK_565) begin : g_pack565
        assign sd_word = SD_DATA_W'(pack_pixel(buf_rd_data[23:0]));
    end else begin : g_trunc
        localparam int EXT_W = (PX_W > SD_DATA_W) ? PX_W : SD_DATA_W;
        logic [EXT_W-1:0] px_ext;
        assign px_ext  = EXT_W'(buf_rd_data);
        assign sd_word = px_ext[SD_DATA_W-1:0];
    end

    assign bus.rd_data    = rd_valid_q ? buf_rd_data : rd_hold_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.busy       = busy_q;
    assign bus.sd_write   = sd_write_q;
    assign bus.sd_wdata   = sd_word;
    assign bus.sd_address = sd_address_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_output_controller.sv
// Scoreboard bench for frame_output_controller (default parameters); follows
// FRAME_OUT_CLEAR_EN when the same macro is defined for the bench.
module tb_frame_output_controller;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
    } sd_exp_t;

    logic clk;
    logic rst;

    frame_output_controller_if #(
        .IDX_W(8), .PX_W(24), .SD_DATA_W(16), .SD_ADDR_W(32)
    ) bus ();

    frame_output_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          fr_cyc   = 0;
    logic [23:0] model [256];
    logic [23:0] exp_rd_q [$];
    sd_exp_t     exp_sd_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_pack(input logic [23:0] p);
        return {p[23:19], p[15:10], p[7:3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_px(input logic [7:0] i, input logic [23:0] d, input bit dropped);
        bus.wr_en    = 1'b1;
        bus.px_index = i;
        bus.wr_data  = d;
        if (!dropped) model[i] = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd_px(input logic [7:0] i, input bit dropped);
        bus.rd_en    = 1'b1;
        bus.px_index = i;
        if (!dropped) exp_rd_q.push_back(model[i]);
        tick();
        bus.rd_en = 1'b0;
    endtask

    // push_words=0 models a coalesced request; zero=1 models a tile already cleared by a flush.
    task automatic pulse_fr(input bit push_words, input bit zero);
        sd_exp_t e;
        if (push_words) begin
            for (int i = 0; i < 256; i++) begin
                e.addr = 32'(i * 2);
                e.data = zero ? 16'h0 : exp_pack(model[i]);
                exp_sd_q.push_back(e);
            end
        end
        bus.frame_ready = 1'b1;
        fr_cyc = cyc;
        tick();
        bus.frame_ready = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", 64'(done_cnt), 64'(target));
    endtask

    always @(negedge clk) begin
        logic [23:0] er;
        sd_exp_t     es;
        if (!rst) begin
            if (bus.rd_valid) begin
                if (exp_rd_q.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    er = exp_rd_q.pop_front();
                    chk("rd_data", 64'(bus.rd_data), 64'(er));
                end
            end
            if (bus.sd_write) begin
                if (exp_sd_q.size() == 0) begin
                    chk("sd_unexpected", 1, 0);
                end else if (bus.sd_wait) begin
                    chk("sd_hold_addr", 64'(bus.sd_address), 64'(exp_sd_q[0].addr));
                    chk("sd_hold_data", 64'(bus.sd_wdata), 64'(exp_sd_q[0].data));
                end else begin
                    es = exp_sd_q.pop_front();
                    chk("sd_addr", 64'(bus.sd_address), 64'(es.addr));
                    chk("sd_data", 64'(bus.sd_wdata), 64'(es.data));
`ifdef FRAME_OUT_CLEAR_EN
                    model[es.addr[8:1]] = 24'h0;
`endif
                end
            end
            if (bus.frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        bit clear_en;
        bit found;
        int dc;
`ifdef FRAME_OUT_CLEAR_EN
        clear_en = 1'b1;
`else
        clear_en = 1'b0;
`endif
        rst = 1'b1;
        bus.px_index = '0; bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0;
        bus.frame_ready = 1'b0; bus.sd_wait = 1'b0;
        for (int i = 0; i < 256; i++) model[i] = 24'h0;
        repeat (3) tick();
        chk("rst_rd_valid",   64'(bus.rd_valid),   0);
        chk("rst_rd_data",    64'(bus.rd_data),    0);
        chk("rst_busy",       64'(bus.busy),       0);
        chk("rst_sd_write",   64'(bus.sd_write),   0);
        chk("rst_sd_address", 64'(bus.sd_address), 0);
        chk("rst_frame_done", 64'(bus.frame_done), 0);
        rst = 1'b0;
        tick();

        // Write then read back; same-cycle write/read returns the old value.
        wr_px(8'd5, 24'hFF8040, 1'b0);
        rd_px(8'd5, 1'b0);
        wr_px(8'd7, 24'h000000, 1'b0);
        bus.rd_en = 1'b1;
        exp_rd_q.push_back(model[7]);
        wr_px(8'd7, 24'h123456, 1'b0);
        bus.rd_en = 1'b0;
        rd_px(8'd7, 1'b0);
        repeat (3) tick();
        chk("rd_q_drained", 64'(exp_rd_q.size()), 0);
        chk("rd_hold", 64'(bus.rd_data), 64'h123456);

        // Full tile flush with no stalls.
        for (int i = 0; i < 256; i++) wr_px(8'(i), {8'(i), 8'(i), 8'(i)}, 1'b0);
        pulse_fr(1'b1, 1'b0);
        chk("busy_set", 64'(bus.busy), 1);
        wait_done(1, 2000);
        chk("done_latency", 64'(done_cyc - fr_cyc), 513);
        chk("sd_q_drained", 64'(exp_sd_q.size()), 0);
        repeat (2) tick();
        chk("busy_clear", 64'(bus.busy), 0);

        // Stall word 3 for ten cycles.
        pulse_fr(1'b1, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            if (bus.sd_write && bus.sd_address == 32'h6) found = 1'b1;
            else tick();
        end
        chk("wait_point_hit", 64'(found), 1);
        bus.sd_wait = 1'b1;
        repeat (10) tick();
        bus.sd_wait = 1'b0;
        wait_done(2, 2000);
        chk("sd_q_drained_wait", 64'(exp_sd_q.size()), 0);

        // Mid-flush request queues one more flush; a further one coalesces; blender ignored.
        pulse_fr(1'b1, 1'b0);
        repeat (40) tick();
        wr_px(8'd10, 24'hABCDEF, 1'b1);
        rd_px(8'd10, 1'b1);
        pulse_fr(1'b1, clear_en);
        repeat (20) tick();
        pulse_fr(1'b0, 1'b0);
        wait_done(4, 3000);
        chk("sd_q_drained_pend", 64'(exp_sd_q.size()), 0);
        repeat (10) tick();
        chk("no_extra_flush", 64'(bus.busy), 0);
        rd_px(8'd10, 1'b0);
        repeat (2) tick();
        chk("rd_q_drained_busy", 64'(exp_rd_q.size()), 0);

        // Reset at word 100 abandons the flush; new flush restarts at the base address.
        pulse_fr(1'b1, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 1000 && !found; n++) begin
            if (bus.sd_write && bus.sd_address == 32'd200) found = 1'b1;
            else tick();
        end
        chk("rst_point_hit", 64'(found), 1);
        dc = done_cnt;
        rst = 1'b1;
        #1;
        chk("rst_sd_write_async", 64'(bus.sd_write), 0);
        exp_sd_q.delete();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_no_done", 64'(done_cnt), 64'(dc));
        chk("rst_busy_low", 64'(bus.busy), 0);
        pulse_fr(1'b1, 1'b0);
        wait_done(dc + 1, 2000);
        chk("sd_q_drained_rst", 64'(exp_sd_q.size()), 0);
        pulse_fr(1'b1, 1'b0);
        wait_done(dc + 2, 2000);
        chk("sd_q_drained_final", 64'(exp_sd_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
